// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   IF stage of the 5-stage MIPS pipeline. Owns the program counter, the
//   instruction memory and the IF/ID pipeline register. While the core is
//   IDLE the memory is loaded word by word through the load port. In RUN the
//   stage fetches one word per cycle, honouring halt, flush (redirect) and
//   stall requests coming back from ID.
//
// Ports
//   i_clk             clock, all state updates on the rising edge
//   i_reset           synchronous active-high reset (wins over everything)
//   i_load_en         write i_load_data to mem[i_load_addr] (IDLE only)
//   i_load_addr       word address for the load port
//   i_load_data       instruction word to load
//   i_start           IDLE -> RUN, fetch begins at PC 0
//   i_pc_write        0 = hazard stall: hold PC and IF/ID
//   i_flush           redirect PC to i_jump_direction and squash IF/ID
//   i_jump_direction  byte target of the redirect
//   i_halt            halt decoded in ID: freeze the stage
//   o_instruccion     IF/ID instruction (0 = NOP when squashed)
//   o_pc_4            IF/ID PC+4 of that instruction
//   o_valid           IF/ID holds a real fetched instruction
//   o_pc              current PC register
//   o_state           00 IDLE, 01 RUN, 10 HALTED
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter int N_BITS      = 32,
  parameter int N_ADDR_BITS = 8,
  parameter int MEM_DEPTH   = 256
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_load_en,
  input  logic [N_ADDR_BITS-1:0] i_load_addr,
  input  logic [N_BITS-1:0]      i_load_data,
  input  logic                   i_start,
  input  logic                   i_pc_write,
  input  logic                   i_flush,
  input  logic [N_BITS-1:0]      i_jump_direction,
  input  logic                   i_halt,
  output logic [N_BITS-1:0]      o_instruccion,
  output logic [N_BITS-1:0]      o_pc_4,
  output logic                   o_valid,
  output logic [N_BITS-1:0]      o_pc,
  output logic [1:0]             o_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_t;

  localparam logic [N_BITS-1:0] PC_STEP = N_BITS'(4);

  state_t                  state;
  logic [N_BITS-1:0]       pc;
  logic [N_BITS-1:0]       pc_plus_4;
  logic [N_ADDR_BITS-1:0]  fetch_idx;
  logic [N_BITS-1:0]       fetch_word;
  logic [N_BITS-1:0]       mem [MEM_DEPTH];

  // Word index drops the byte offset; PC bits above the memory range are
  // ignored so the fetch address wraps modulo 4*MEM_DEPTH.
  assign fetch_idx  = pc[N_ADDR_BITS+1:2];
  assign fetch_word = mem[fetch_idx];
  assign pc_plus_4  = pc + PC_STEP;

  // Bits that take no part in addressing, collected to document that.
  logic unused_bits;
  assign unused_bits = ^{pc[N_BITS-1:N_ADDR_BITS+2], pc[1:0], i_jump_direction[1:0]};

  // NOTE: the program memory has no reset; its contents must survive a core
  // reset so a program can be rerun without reloading it.
  always_ff @(posedge i_clk) begin
    if (!i_reset && state == IDLE && i_load_en) begin
      mem[i_load_addr] <= i_load_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      pc            <= '0;
      o_instruccion <= '0;
      o_pc_4        <= '0;
      o_valid       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            state <= RUN;
            pc    <= '0;
          end
        end

        RUN: begin
          if (i_halt) begin
            state         <= HALTED;
            o_instruccion <= '0;
            o_valid       <= 1'b0;
          end else if (i_flush) begin
            // A flush beats a stall: the stalled instruction in ID is the jump.
            pc            <= {i_jump_direction[N_BITS-1:2], 2'b00};
            o_instruccion <= '0;
            o_valid       <= 1'b0;
          end else if (i_pc_write) begin
            o_instruccion <= fetch_word;
            o_pc_4        <= pc_plus_4;
            o_valid       <= 1'b1;
            pc            <= pc_plus_4;
          end
        end

        HALTED: begin
          // Frozen until reset.
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign o_pc    = pc;
  assign o_state = state;

endmodule
